text_render_gen: RTL
====================

Name: text_render_gen

Overview:
- Parametrised text-mode pixel renderer; successor to the 40-column mono text block.
- Takes pixel coordinates and timing from the VGA timing generator and fetches a character+attribute word from display memory, then the glyph row from font memory.
- Emits a 4-bit colour index per pixel with syncs delayed to match.
- Adds configurable grid size, per-cell fg/bg colour, out-of-grid border colour and a fixed, documented pipeline latency.

Parameters:
- COLS, 40, characters per row (1..128)
- ROWS, 30, character rows (1..64)
- CHAR_H, 16, glyph height in pixels; power of two, 8 or 16
- PIX_W, 10, width of pix_x/pix_y
- ADDR_W, 12, display memory address width; must satisfy COLS*ROWS <= 2^ADDR_W
- BORDER, 4'h0, colour index outside the text grid or when blanked
- BLINK_LOG2, 5, cursor blink period = 2^BLINK_LOG2 frames (used only with TXT_CURSOR_EN)

Ports:
- clk  in  1  pixel clock
- clr  in  1  asynchronous active-high reset
- pix_x  in  PIX_W  current pixel column from timing generator
- pix_y  in  PIX_W  current pixel row
- pix_de  in  1  active-video flag
- hs_in / vs_in  in  1 each  syncs from timing generator
- disp_addr  out  ADDR_W  display memory address
- disp_en  out  1  display memory read enable
- disp_dat  in  16  [7:0] ascii, [11:8] fg, [15:12] bg
- font_addr  out  8+log2(CHAR_H)  {ascii, glyph row}
- font_en  out  1  font memory read enable
- font_dat  in  8  glyph row; bit 7 = leftmost pixel
- pix_col  out  4  colour index
- hs_out / vs_out / de_out  out  1 each  syncs and DE delayed by LAT

Behaviour:
- Reset: clr is asynchronous and active-high. Every output and pipeline register clears to 0 (pix_col = 0, not BORDER).
- Glyph width is fixed at 8. col = pix_x>>3, row = pix_y>>log2(CHAR_H), gx = pix_x[2:0], gy = pix_y mod CHAR_H.
- in_grid = pix_de && col<COLS && row<ROWS.
- Memories are synchronous: data is valid in the cycle after enable/address are driven.
- Pipeline, with edges counted from the edge Ek that samples the inputs:
  - E1: disp_addr <= row*COLS+col, truncated to ADDR_W, computed at full width first. disp_en <= in_grid. gx, gy, in_grid, de and syncs go into the delay line.
  - E3: font_addr <= {disp_dat[7:0], gy_d2}; font_en <= in_grid_d2; fg/bg latched.
  - E5: pix_col <= in_grid_d4 ? (font_dat[7-gx_d4] ? fg_d4 : bg_d4) : BORDER, forced to 0 when de_d4 = 0. hs_out, vs_out and de_out are updated from the same delay stage.
- LAT = 5 clocks, constant for all pixels.
- Enables are high only for in-grid pixels. A fetch is issued every in-grid pixel, with no per-character caching.
- Disabled-enable cycles hold the previous address value.
- Grid boundary: col = COLS-1 is in grid; col = COLS gives BORDER from its first pixel. The same rule applies to rows.
- Reset mid-frame flushes all in-flight pixels. After clr falls, the first LAT outputs are 0 and de_out = 0.

Optional Feature:
- Macro TXT_CURSOR_EN.
- When defined:
  - Extra inputs cur_col (7 bits) and cur_row (6 bits).
  - A frame counter of BLINK_LOG2 bits increments on each rising edge of vs_in and resets to 0.
  - The cursor is visible while counter MSB = 0.
  - When visible, the cell matches the cursor, and gy_d4 >= CHAR_H-2, pix_col = fg_d4 regardless of the glyph bit.
- When undefined: the ports and counter are absent, and behaviour is exactly as above.

Decomposition:
- Package txt_pkg: glyph width constant 8, attribute bit-field positions (ASCII_LSB/MSB, FG_LSB, BG_LSB), LAT = 5, and a colour-index typedef (4-bit).
- One sub-module, txt_delay_line: a parametrised width/depth shift register with async clear, used for the sideband pipeline (gx, gy, in_grid, de, hs, vs).

Test Plan:
- Reset: hold clr for 3 clocks mid-line, then release → all outputs 0 during reset; de_out = 0 for the first 5 clocks after release.
- Address: pix_x = 17, pix_y = 35 with CHAR_H = 16, COLS = 40 → disp_addr = 82 one clock later, disp_en = 1. Then disp_dat = 16'h2A41 → font_addr = {8'h41, 4'd3} two clocks after that.
- Colour: font_dat = 8'b1000_0001, fg = 4'hA, bg = 4'h2, gx sweeping 0..7 → pix_col = A,2,2,2,2,2,2,A, each 5 clocks after its input pixel.
- Boundary: pix_x = 319 vs 320 (COLS = 40) → first in grid with font fetch; second gives pix_col = BORDER and disp_en = 0. pix_de = 0 → pix_col = 0.
- Latency: a single-cycle pulse on hs_in and vs_in → hs_out and vs_out pulse exactly 5 clocks later; de_out tracks pix_de with the same delay.
- TXT_CURSOR_EN: cur = (2,1), BLINK_LOG2 = 2, CHAR_H = 16, glyph row 14 with font_dat = 0 → pix_col = fg on frames 0–1 and bg on frames 2–3 of each 4-frame period.

Source files
------------

// File: rtl/txt_pkg.sv
// txt_pkg: shared constants and types for the text-mode renderer
package txt_pkg;
  localparam int GLYPH_W = 8;
  localparam int ASCII_LSB = 0;
  localparam int ASCII_MSB = 7;
  localparam int FG_LSB = 8;
  localparam int BG_LSB = 12;
  localparam int LAT = 5;
  typedef logic [3:0] colour_t;
endpackage

// File: rtl/txt_delay_line.sv
// txt_delay_line: W-bit wide, D-deep shift register with async clear
module txt_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [D];
  always_ff @(posedge clk or posedge clr)
    if (clr) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[D-1];
endmodule

// File: rtl/text_render_gen.sv
// text_render_gen: text-mode pixel renderer with fixed 5-clock latency
// Optional blinking underline cursor enabled by TXT_CURSOR_EN
module text_render_gen import txt_pkg::*; #(
  parameter int      COLS   = 40,
  parameter int      ROWS   = 30,
  parameter int      CHAR_H = 16,
  parameter int      PIX_W  = 10,
  parameter int      ADDR_W = 12,
  parameter colour_t BORDER = 4'h0
`ifdef TXT_CURSOR_EN
  , parameter int    BLINK_LOG2 = 5
`endif
) (
  input  logic                          clk,
  input  logic                          clr,
`ifdef TXT_CURSOR_EN
  input  logic [6:0]                    cur_col,
  input  logic [5:0]                    cur_row,
`endif
  input  logic [PIX_W-1:0]              pix_x,
  input  logic [PIX_W-1:0]              pix_y,
  input  logic                          pix_de,
  input  logic                          hs_in,
  input  logic                          vs_in,
  output logic [ADDR_W-1:0]             disp_addr,
  output logic                          disp_en,
  input  logic [15:0]                   disp_dat,
  output logic [8+$clog2(CHAR_H)-1:0]   font_addr,
  output logic                          font_en,
  input  logic [7:0]                    font_dat,
  output colour_t                       pix_col,
  output logic                          hs_out,
  output logic                          vs_out,
  output logic                          de_out
);
  localparam int GYW = $clog2(CHAR_H);
  localparam int GXW = $clog2(GLYPH_W);
  localparam int SBW = GXW + GYW + 5;
  localparam int AW = 2*PIX_W + 8;
  logic [PIX_W-1:0] col, row;
  logic [AW-1:0] lin;
  logic in_grid, hit, vis, cur_on;
  logic [SBW-1:0] sb0, sb2, sb4;
  logic [7:0] attr4;
  logic [GYW-1:0] gy2, gy4;
  logic [GXW-1:0] gx4;
  logic ig2, ig4, de4, hs4, vs4, hit4;
  assign col = pix_x >> GXW;
  assign row = pix_y >> GYW;
  assign in_grid = pix_de && 32'(col) < COLS && 32'(row) < ROWS;
  assign lin = AW'(row) * AW'(COLS) + AW'(col);
`ifdef TXT_CURSOR_EN
  logic [BLINK_LOG2-1:0] frame;
  logic vs_q;
  assign hit = 32'(col) == 32'(cur_col) && 32'(row) == 32'(cur_row);
  assign vis = !frame[BLINK_LOG2-1];
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      frame <= '0;
      vs_q <= 1'b0;
    end else begin
      vs_q <= vs_in;
      frame <= frame + BLINK_LOG2'(vs_in && !vs_q);
    end
`else
  assign hit = 1'b0;
  assign vis = 1'b0;
`endif
  // sideband travels alongside the two memory reads: tap at stage 2 for the font fetch, stage 4 for colour
  assign sb0 = {hit, vs_in, hs_in, pix_de, in_grid, pix_y[GYW-1:0], pix_x[GXW-1:0]};
  txt_delay_line #(.W(SBW), .D(2)) u_dl_a (.clk(clk), .clr(clr), .d(sb0), .q(sb2));
  txt_delay_line #(.W(SBW), .D(LAT-3)) u_dl_b (.clk(clk), .clr(clr), .d(sb2), .q(sb4));
  txt_delay_line #(.W(8), .D(LAT-3)) u_dl_c (.clk(clk), .clr(clr), .d(disp_dat[BG_LSB+3:FG_LSB]), .q(attr4));
  assign gy2 = sb2[GXW +: GYW];
  assign ig2 = sb2[GXW+GYW];
  assign {hit4, vs4, hs4, de4, ig4, gy4, gx4} = sb4;
  assign cur_on = vis && hit4 && 32'(gy4) >= CHAR_H-2;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      disp_addr <= '0;
      disp_en <= 1'b0;
      font_addr <= '0;
      font_en <= 1'b0;
      pix_col <= '0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      de_out <= 1'b0;
    end else begin
      disp_en <= in_grid;
      if (in_grid) disp_addr <= lin[ADDR_W-1:0];
      font_en <= ig2;
      if (ig2) font_addr <= {disp_dat[ASCII_MSB:ASCII_LSB], gy2};
      pix_col <= !de4 ? '0 : !ig4 ? BORDER : (cur_on || font_dat[3'd7 - gx4]) ? attr4[3:0] : attr4[7:4];
      hs_out <= hs4;
      vs_out <= vs4;
      de_out <= de4;
    end
endmodule
